ram_dual_port_bist: RTL and testbench

Built-in self-test initiator that drives both ports of the 128x8 true dual-port RAM (ram_true_dual_port) at the same time.
- Writes a data pattern through both ports, reads it back, compares, then repeats with the inverted pattern.
- Reports pass/fail, a saturating error count and the first failing address.
- Sits between the RAM and the lab top level; owns a1/a2/d1/d2/we1/we2 whenever it is busy.

---
 rtl/ram_bist_pkg.sv | 8 +
 rtl/ram_bist_checker.sv | 34 +++
 rtl/ram_dual_port_bist.sv | 111 +++++++++++
 tb/tb_ram_dual_port_bist.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, default sizes, base pattern and error-count ceiling
package ram_bist_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam logic [7:0] BIST_PATTERN = 8'hCC;
  localparam logic [7:0] ERR_MAX = 8'd255;
endpackage

// File: rtl/ram_bist_checker.sv
// ram_bist_checker: compares both read ports, counts mismatches (saturating) and captures the first failing address
module ram_bist_checker import ram_bist_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clr,
  input  logic              chk,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] e1,
  input  logic [DATA_W-1:0] e2,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr
);
  logic m1, m2;
  logic [8:0] sum;
  assign m1 = q1 != e1;
  assign m2 = q2 != e2;
  assign sum = {1'b0, err_count} + 9'(m1) + 9'(m2);
  // err_count stays nonzero once hit, so zero doubles as "no failure captured yet"
  always_ff @(posedge clk1) begin
    if (rst || clr) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (chk) begin
      err_count <= sum > 9'(ERR_MAX) ? ERR_MAX : sum[7:0];
      if ((m1 || m2) && err_count == 8'd0) fail_addr <= m1 ? a1 : a2;
    end
  end
endmodule

// File: rtl/ram_dual_port_bist.sv
// ram_dual_port_bist: two-port RAM self-test (pattern, inverted pattern; RAM_BIST_ADDR_PATTERN_EN adds an address-as-data pass)
module ram_dual_port_bist import ram_bist_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] PATTERN = BIST_PATTERN
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic              we1,
  output logic              we2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr
);
`ifdef RAM_BIST_ADDR_PATTERN_EN
  localparam int P_W = 2;
  localparam int P_LAST = 2;
`else
  localparam int P_W = 1;
  localparam int P_LAST = 1;
`endif
  state_t state;
  logic [ADDR_W-2:0] k;
  logic [P_W-1:0] p;
  logic [1:0] cnt;
  logic act, go;
  logic [DATA_W-1:0] e1, e2;
  assign act = state != IDLE;
  assign go = start && (state == IDLE || state == DONE);
  assign a1 = act ? {k, 1'b1} : '0;
  assign a2 = act ? {k, 1'b0} : '0;
`ifdef RAM_BIST_ADDR_PATTERN_EN
  assign e1 = (p == 2'd2) ? DATA_W'(a1) : PATTERN ^ {DATA_W{p[0]}};
`else
  assign e1 = PATTERN ^ {DATA_W{p[0]}};
`endif
  assign e2 = e1 ^ DATA_W'(1);
  assign d1 = act ? e1 : '0;
  assign d2 = act ? e2 : '0;
  assign we1 = state == WRITE;
  assign we2 = we1;
  assign pass = done && err_count == 8'd0;
  // sequencer: write all pairs, then read/check each pair, once per pass
  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      p <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= WRITE;
          k <= '0;
          p <= '0;
          busy <= 1'b1;
          done <= 1'b0;
        end
        WRITE: begin
          k <= k + 1'b1;
          if (&k) state <= READ;
        end
        READ: begin
          cnt <= (cnt == 2'(READ_LAT - 1)) ? 2'd0 : cnt + 2'd1;
          if (cnt == 2'(READ_LAT - 1)) state <= CHECK;
        end
        CHECK: begin
          if (!(&k)) begin
            k <= k + 1'b1;
            state <= READ;
          end else if (p != P_W'(P_LAST)) begin
            p <= p + 1'b1;
            k <= '0;
            state <= WRITE;
          end else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  ram_bist_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
    .clk1(clk1),
    .rst(rst),
    .clr(go),
    .chk(state == CHECK),
    .q1(q1),
    .q2(q2),
    .e1(e1),
    .e2(e2),
    .a1(a1),
    .a2(a2),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );
endmodule

// File: tb/tb_ram_dual_port_bist.sv
// tb_ram_dual_port_bist: BIST against a behavioural 128x8 dual-port RAM with injectable faults
module tb_ram_dual_port_bist;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] q1, q2, d1, d2, err_count;
  logic [6:0] a1, a2, fail_addr;
  logic we1, we2, busy, done, pass;
  logic [7:0] mem [128];
  logic [7:0] q1r, q2r;
  int checks = 0;
  int failures = 0;
  int fault = 0;
  typedef struct {int lat; int err; int fa; int ps;} exp_t;
  exp_t sb [$];

  always #5 clk1 = ~clk1;

  ram_dual_port_bist dut (
    .clk1(clk1), .rst(rst), .start(start), .q1(q1), .q2(q2),
    .a1(a1), .a2(a2), .d1(d1), .d2(d2), .we1(we1), .we2(we2),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
  );

  // RAM model, one-cycle registered read; fault 1 = data bit0 of word 7'h79 stuck at 0
  always @(posedge clk1) begin
    if (we1) mem[a1] <= (fault == 1 && a1 == 7'h79) ? (d1 & 8'hFE) : d1;
    if (we2) mem[a2] <= (fault == 1 && a2 == 7'h79) ? (d2 & 8'hFE) : d2;
    q1r <= mem[a1];
    q2r <= mem[a2];
  end
  // fault 2 = port 2 shorted to port 1, fault 3 = both read ports stuck at 0
  assign q1 = (fault == 3) ? 8'h00 : q1r;
  assign q2 = (fault == 3) ? 8'h00 : (fault == 2) ? q1 : q2r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic run(input int f, input int lat, input int err, input int fa, input int ps,
                     input int pa, input int pb, input bit first);
    int n = 1;
    int bc = 0;
    int wc = 0;
    exp_t e;
    fault = f;
    sb.push_back('{lat, err, fa, ps});
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 1000) begin
      if (n == 1 && first) begin
        check("first_a1", a1, 7'h01);
        check("first_d1", d1, 8'hCC);
        check("first_a2", a2, 7'h00);
        check("first_d2", d2, 8'hCD);
        check("first_we", {we1, we2}, 2'b11);
      end
      bc += int'(busy);
      wc += int'(we1);
      start = (n == pa || n == pb);
      tick();
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done_lat", n, e.lat);
    check("busy_cycles", bc, 384);
    check("we_cycles", wc, 128);
    check("err_count", err_count, e.err);
    check("fail_addr", fail_addr, e.fa);
    check("pass", pass, e.ps);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_a1", a1, 0);
    check("rst_a2", a2, 0);
    check("rst_d1", d1, 0);
    check("rst_d2", d2, 0);
    check("rst_we", {we1, we2}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fa", fail_addr, 0);
    rst = 1'b0;
    tick();
    run(0, 385, 0, 0, 1, 0, 0, 1'b1);
    run(1, 385, 1, 7'h79, 0, 0, 0, 1'b0);
    run(2, 385, 128, 7'h00, 0, 0, 0, 1'b0);
    run(3, 385, 255, 7'h01, 0, 0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_err", err_count, 0);
    check("rst_done_fa", fail_addr, 0);
    check("rst_done_done", done, 0);
    check("rst_done_pass", pass, 0);
    fault = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid_we_before", we1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_we", {we1, we2}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err_count, 0);
    tick();
    run(0, 385, 0, 0, 1, 0, 0, 1'b1);
    run(0, 385, 0, 0, 1, 50, 200, 1'b0);
    repeat (5) tick();
    check("done_hold", done, 1);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
